// File: rtl/lstm_step_sequencer.sv
// lstm_step_sequencer: feeds one LSTM layer. Collects NUM input words per step,
// presents {h(t-1), x(t)} and c(t-1) to the cells, captures h(t)/c(t) when the
// cells report, and clears the recurrent state at the end of each sequence.
module lstm_step_sequencer #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned NUM      = 68,
    parameter int unsigned NUM_LSTM = 8,
    parameter int unsigned SEQ_LEN  = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                i_clear,
    input  logic                                i_x_valid,
    input  logic [WIDTH-1:0]                    i_x_data,
    output logic                                o_x_ready,
    output logic [(NUM+NUM_LSTM)*WIDTH-1:0]     o_x,
    output logic [NUM_LSTM*WIDTH-1:0]           o_prev_state,
    output logic                                o_valid,
    input  logic                                i_res_valid,
    input  logic [NUM_LSTM*WIDTH-1:0]           i_h,
    input  logic [NUM_LSTM*WIDTH-1:0]           i_c,
    output logic [$clog2(SEQ_LEN+1)-1:0]        o_step,
    output logic                                o_seq_done
);

    localparam int unsigned IDX_W  = (NUM > 1) ? $clog2(NUM) : 1;
    localparam int unsigned STEP_W = $clog2(SEQ_LEN + 1);
    localparam int unsigned HC_W   = NUM_LSTM * WIDTH;
    localparam int unsigned XIN_W  = NUM * WIDTH;

    typedef enum logic {
        S_LOAD = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_accept;
    logic                w_capture;
    logic                w_last_word;
    logic                w_last_step;

    logic [WIDTH-1:0]    r_x [NUM];
    logic [IDX_W-1:0]    r_widx;
    logic [HC_W-1:0]     r_h;
    logic [HC_W-1:0]     r_c;
    logic [STEP_W-1:0]   r_step;
    logic                r_seq_done;
    logic [XIN_W-1:0]    w_x_flat;

    assign w_last_word = (r_widx == IDX_W'(NUM - 1));
    assign w_last_step = (r_step == STEP_W'(SEQ_LEN - 1));

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, handshake outputs and datapath strobes; clear overrides everything
    always_comb begin
        w_state_nxt = r_state;
        o_x_ready   = 1'b0;
        o_valid     = 1'b0;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            S_LOAD: begin
                o_x_ready = 1'b1;
                if (i_x_valid) begin
                    w_accept = 1'b1;
                    if (w_last_word) begin
                        w_state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                o_valid = 1'b1;
                if (i_res_valid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_LOAD;
                end
            end
            default: begin
                w_state_nxt = S_LOAD;
            end
        endcase
        if (i_clear) begin
            w_state_nxt = S_LOAD;
            w_accept    = 1'b0;
            w_capture   = 1'b0;
        end
    end

    // Input word store; reset wipes it, clear leaves the stale words in place
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < int'(NUM); k++) begin
                r_x[k] <= '0;
            end
        end else if (w_accept) begin
            r_x[r_widx] <= i_x_data;
        end
    end

    // Word index, recurrent state, step counter and end-of-sequence pulse
    always_ff @(posedge clk) begin
        if (!rst || i_clear) begin
            r_widx     <= '0;
            r_h        <= '0;
            r_c        <= '0;
            r_step     <= '0;
            r_seq_done <= 1'b0;
        end else begin
            r_seq_done <= 1'b0;
            if (w_accept) begin
                r_widx <= w_last_word ? '0 : r_widx + IDX_W'(1);
            end
            if (w_capture) begin
                if (w_last_step) begin
                    r_h        <= '0;
                    r_c        <= '0;
                    r_step     <= '0;
                    r_seq_done <= 1'b1;
                end else begin
                    r_h    <= i_h;
                    r_c    <= i_c;
                    r_step <= r_step + STEP_W'(1);
                end
            end
        end
    end

    // Flatten the word store: word k lands at bits [k*WIDTH +: WIDTH]
    genvar g;
    generate
        for (g = 0; g < int'(NUM); g++) begin : g_xpack
            assign w_x_flat[g*WIDTH +: WIDTH] = r_x[g];
        end
    endgenerate

    assign o_x          = {r_h, w_x_flat};
    assign o_prev_state = r_c;
    assign o_step       = r_step;
    assign o_seq_done   = r_seq_done;

endmodule

// File: tb/tb_lstm_step_sequencer.sv
// Self-checking bench for lstm_step_sequencer (NUM=4, NUM_LSTM=2, SEQ_LEN=3).
module tb_lstm_step_sequencer;

    localparam int unsigned WIDTH    = 32;
    localparam int unsigned NUM      = 4;
    localparam int unsigned NUM_LSTM = 2;
    localparam int unsigned SEQ_LEN  = 3;
    localparam int unsigned XW       = (NUM + NUM_LSTM) * WIDTH;
    localparam int unsigned HW       = NUM_LSTM * WIDTH;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            i_clear = 1'b0;
    logic            i_x_valid = 1'b0;
    logic [WIDTH-1:0] i_x_data = '0;
    logic            o_x_ready;
    logic [XW-1:0]   o_x;
    logic [HW-1:0]   o_prev_state;
    logic            o_valid;
    logic            i_res_valid = 1'b0;
    logic [HW-1:0]   i_h = '0;
    logic [HW-1:0]   i_c = '0;
    logic [1:0]      o_step;
    logic            o_seq_done;

    lstm_step_sequencer #(
        .WIDTH(WIDTH), .NUM(NUM), .NUM_LSTM(NUM_LSTM), .SEQ_LEN(SEQ_LEN)
    ) dut (
        .clk(clk), .rst(rst), .i_clear(i_clear),
        .i_x_valid(i_x_valid), .i_x_data(i_x_data), .o_x_ready(o_x_ready),
        .o_x(o_x), .o_prev_state(o_prev_state), .o_valid(o_valid),
        .i_res_valid(i_res_valid), .i_h(i_h), .i_c(i_c),
        .o_step(o_step), .o_seq_done(o_seq_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [XW-1:0] x;
        logic [HW-1:0] prev;
    } exp_t;

    exp_t sb_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [WIDTH-1:0] m_x [NUM];
    logic [HW-1:0]    m_h;
    logic [HW-1:0]    m_c;
    int               m_widx;
    int               m_step;
    bit               m_wait;
    bit               m_done;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [XW-1:0] model_x();
        logic [XW-1:0] v;
        v = '0;
        for (int k = 0; k < int'(NUM); k++) v[k*WIDTH +: WIDTH] = m_x[k];
        v[NUM*WIDTH +: HW] = m_h;
        return v;
    endfunction

    // One clock: drive inputs, advance the model at the edge, check at the falling edge
    task automatic cycle(input logic rst_v, input logic xv, input logic [WIDTH-1:0] xd,
                         input logic rv, input logic [HW-1:0] h, input logic [HW-1:0] c,
                         input logic clr);
        exp_t e;
        rst = rst_v; i_x_valid = xv; i_x_data = xd; i_res_valid = rv;
        i_h = h; i_c = c; i_clear = clr;
        @(posedge clk);
        m_done = 1'b0;
        if (!rst_v) begin
            for (int k = 0; k < int'(NUM); k++) m_x[k] = '0;
            m_h = '0; m_c = '0; m_widx = 0; m_step = 0; m_wait = 1'b0;
        end else if (clr) begin
            m_h = '0; m_c = '0; m_widx = 0; m_step = 0; m_wait = 1'b0;
        end else if (!m_wait) begin
            if (xv) begin
                m_x[m_widx] = xd;
                if (m_widx == int'(NUM) - 1) begin
                    m_widx = 0;
                    m_wait = 1'b1;
                    e.x    = model_x();
                    e.prev = m_c;
                    sb_q.push_back(e);
                end else begin
                    m_widx++;
                end
            end
        end else if (rv) begin
            m_wait = 1'b0;
            if (m_step == int'(SEQ_LEN) - 1) begin
                m_h = '0; m_c = '0; m_step = 0; m_done = 1'b1;
            end else begin
                m_h = h; m_c = c; m_step++;
            end
        end
        @(negedge clk);
        check("o_valid",    256'(o_valid),    256'(m_wait));
        check("o_x_ready",  256'(o_x_ready),  256'(!m_wait));
        check("o_step",     256'(o_step),     256'(m_step));
        check("o_seq_done", 256'(o_seq_done), 256'(m_done));
        check("o_x",        256'(o_x),        256'(model_x()));
        check("o_prev",     256'(o_prev_state), 256'(m_c));
        i_x_valid = 1'b0; i_res_valid = 1'b0; i_clear = 1'b0;
    endtask

    task automatic push(input logic [WIDTH-1:0] v);
        cycle(1'b1, 1'b1, v, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic idle();
        cycle(1'b1, 1'b0, '0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic res(input logic [HW-1:0] h, input logic [HW-1:0] c);
        cycle(1'b1, 1'b0, '0, 1'b1, h, c, 1'b0);
    endtask

    // Scoreboard: each completed vector is compared when o_valid rises
    bit prev_valid = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (o_valid && !prev_valid) begin
            if (sb_q.size() == 0) begin
                check("sb_underflow", 256'(1), 256'(0));
            end else begin
                e = sb_q.pop_front();
                check("sb_x",    256'(o_x),          256'(e.x));
                check("sb_prev", 256'(o_prev_state), 256'(e.prev));
            end
        end
        prev_valid = o_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < int'(NUM); k++) m_x[k] = '0;
        m_h = '0; m_c = '0; m_widx = 0; m_step = 0; m_wait = 1'b0; m_done = 1'b0;

        // Reset
        cycle(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b0);

        // Step 0: back-to-back load, extra words in WAIT ignored
        push(32'd1); push(32'd2); push(32'd3); push(32'd4);
        push(32'd99); push(32'd98);
        res({32'h11, 32'h10}, {32'h21, 32'h20});

        // Step 1: h/c from step 0 appear in the vector
        push(32'd5); push(32'd6); push(32'd7); push(32'd8);
        idle();
        res({32'h31, 32'h30}, {32'h41, 32'h40});

        // Step 2 (last): capture clears state and pulses seq_done
        push(32'hDEAD_0001); push(32'hFFFF_FFFF); push(32'h8000_0000); push(32'h7FFF_FFFF);
        res({32'h51, 32'h50}, {32'h61, 32'h60});
        idle();

        // Gapped input with result pulses during LOAD (ignored)
        push(32'd9);  res({32'hAA, 32'hAA}, {32'hBB, 32'hBB});
        push(32'd10); idle();
        push(32'd11); res({32'hCC, 32'hCC}, {32'hDD, 32'hDD});
        push(32'd12);
        res({32'h71, 32'h70}, {32'h81, 32'h80});

        // Abort mid-load with clear (same cycle as a valid word)
        push(32'd13); push(32'd14);
        cycle(1'b1, 1'b1, 32'd15, 1'b0, '0, '0, 1'b1);
        for (int i = 0; i < int'(NUM); i++) push($urandom);
        res({32'h91, 32'h90}, {32'hA1, 32'hA0});

        // Clear in WAIT beats a simultaneous result
        for (int i = 0; i < int'(NUM); i++) push(32'(100 + i));
        cycle(1'b1, 1'b0, '0, 1'b1, {32'hEE, 32'hEE}, {32'hEE, 32'hEE}, 1'b1);

        // Reset mid-WAIT discards the step
        for (int i = 0; i < int'(NUM); i++) push(32'(200 + i));
        res({32'h1, 32'h2}, {32'h3, 32'h4});
        for (int i = 0; i < int'(NUM); i++) push(32'(300 + i));
        cycle(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b0);
        for (int i = 0; i < int'(NUM); i++) push(32'(400 + i));
        res({32'h5, 32'h6}, {32'h7, 32'h8});
        idle(); idle();

        check("sb_empty", 256'(sb_q.size()), 256'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
